sha256_loop_sched: RTL and testbench

SHA256_LOOP_SCHED -- requirements
Module: sha256_loop_sched

---
 rtl/sha256_sched_pkg.sv | 31 +++
 rtl/sha256_tag_delay.sv | 49 ++++
 rtl/sha256_loop_sched.sv | 176 +++++++++++++++++
 tb/tb_sha256_loop_sched.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sha256_sched_pkg
// Description : Shared types and constants for the SHA-256 loop scheduler:
//               FSM state encoding, second-chunk padding words, nonce and tag
//               widths, and the helper that assembles the 512-bit block.
// Revision    : 1.0 - initial release
// ============================================================================
package sha256_sched_pkg;

  localparam int NONCE_W = 32;
  localparam int TAG_W   = NONCE_W + 1;

  // Second chunk of an 80-byte header: padding bit and 640-bit length field
  localparam logic [31:0] PAD_START = 32'h80000000;
  localparam logic [31:0] PAD_LEN   = 32'h00000280;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } sched_state_t;

  // Second message chunk for a given nonce: data words occupy the low bits
  function automatic logic [511:0] build_block(input logic [NONCE_W-1:0] nonce,
                                               input logic [95:0]        data);
    return {PAD_LEN, 320'd0, PAD_START, nonce, data};
  endfunction

endpackage
`default_nettype wire

// File: rtl/sha256_tag_delay.sv
`default_nettype none
// ============================================================================
// Module      : sha256_tag_delay
// Description : DEPTH-stage shift pipeline carrying a {valid, nonce} tag in
//               step with the transform, so each result can be matched to the
//               nonce that produced it. Synchronous clear drops every tag.
// Revision    : 1.0 - initial release
// ============================================================================
module sha256_tag_delay
  import sha256_sched_pkg::*;
#(
  parameter int DEPTH = 66
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               in_valid,
  input  logic [NONCE_W-1:0] in_nonce,
  output logic               out_valid,
  output logic [NONCE_W-1:0] out_nonce
);

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic [TAG_W-1:0] prev;
    logic [TAG_W-1:0] q;

    if (i == 0) begin : g_head
      assign prev = {in_valid, in_nonce};
    end else begin : g_tail
      assign prev = g_stage[i-1].q;
    end

    // Advance one stage per cycle; a clear empties the whole pipe at once
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q <= '0;
      end else if (clear) begin
        q <= '0;
      end else begin
        q <= prev;
      end
    end
  end

  assign out_valid = g_stage[DEPTH-1].q[TAG_W-1];
  assign out_nonce = g_stage[DEPTH-1].q[NONCE_W-1:0];

endmodule
`default_nettype wire

// File: rtl/sha256_loop_sched.sv
`default_nettype none
// ============================================================================
// Module      : sha256_loop_sched
// Description : Nonce scheduler for a looped SHA-256 transform. Accepts a job
//               (midstate, data, inclusive nonce range), issues one nonce every
//               LOOP cycles, tracks in-flight nonces through a LAT-deep tag
//               pipe and reports nonces whose hash top word is zero.
//               Optional macro SHA256_SCHED_STATS_EN adds a saturating
//               hash_count output.
// Revision    : 1.0 - initial release
// ============================================================================
module sha256_loop_sched
  import sha256_sched_pkg::*;
#(
  parameter int LOOP = 4,
  parameter int LAT  = 66
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         work_valid,
  output logic         work_ready,
  input  logic [255:0] work_midstate,
  input  logic [95:0]  work_data,
  input  logic [31:0]  nonce_start,
  input  logic [31:0]  nonce_end,
  input  logic         abort,
  output logic         tr_feedback,
  output logic [5:0]   tr_cnt,
  output logic [255:0] tr_state,
  output logic [511:0] tr_input,
  input  logic [255:0] tr_hash,
  output logic         found_valid,
  output logic [31:0]  found_nonce,
  output logic         done
`ifdef SHA256_SCHED_STATS_EN
  ,
  output logic [31:0]  hash_count
`endif
);

  localparam int             DRAIN_W    = $clog2(LAT + 1);
  localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(LAT - 1);
  localparam logic [5:0]     CNT_LAST   = 6'(LOOP - 1);

  sched_state_t       state;
  sched_state_t       state_nxt;
  logic [31:0]        end_nonce;
  logic [DRAIN_W-1:0] drain_cnt;

  logic               accept;
  logic               abort_hit;
  logic               issue;
  logic               last_issue;
  logic               drain_last;
  logic [31:0]        cur_nonce;
  logic               tag_valid;
  logic [31:0]        tag_nonce;
  logic               hit;
  logic               unused_hash_bits;

  // The nonce currently presented lives inside the registered block itself
  assign cur_nonce  = tr_input[127:96];
  assign work_ready = (state == ST_IDLE);
  assign accept     = work_ready && work_valid;
  assign abort_hit  = abort && (state != ST_IDLE);
  assign issue      = (state == ST_RUN) && (tr_cnt == 6'd0) && !abort_hit;
  assign last_issue = issue && (cur_nonce == end_nonce);
  // drain_cnt reaches zero exactly in the cycle the final tag emerges
  assign drain_last = (state == ST_DRAIN) && (drain_cnt == '0);
  assign hit        = tag_valid && (tr_hash[255:224] == 32'd0) && !abort_hit;
  assign tr_feedback = (tr_cnt != 6'd0);
  // Only the top word decides a candidate; the rest is deliberately ignored
  assign unused_hash_bits = ^tr_hash[223:0];

  sha256_tag_delay #(
    .DEPTH(LAT)
  ) u_tag_delay (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (abort_hit),
    .in_valid (issue),
    .in_nonce (cur_nonce),
    .out_valid(tag_valid),
    .out_nonce(tag_nonce)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state selection; abort wins over normal progress
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (work_valid) state_nxt = ST_RUN;
      ST_RUN:   if (abort_hit) state_nxt = ST_IDLE;
                else if (last_issue) state_nxt = ST_DRAIN;
      ST_DRAIN: if (abort_hit || drain_last) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Job context: latched on accept; block advances to the next nonce after each issue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tr_state  <= '0;
      tr_input  <= '0;
      end_nonce <= '0;
    end else if (accept) begin
      tr_state  <= work_midstate;
      tr_input  <= build_block(nonce_start, work_data);
      end_nonce <= nonce_end;
    end else if (issue && !last_issue) begin
      tr_input  <= build_block(cur_nonce + 32'd1, tr_input[95:0]);
    end
  end

  // Round-group counter: free-runs 0..LOOP-1 while busy, parked at zero when idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tr_cnt <= 6'd0;
    end else if (state == ST_IDLE || state_nxt == ST_IDLE) begin
      tr_cnt <= 6'd0;
    end else if (tr_cnt == CNT_LAST) begin
      tr_cnt <= 6'd0;
    end else begin
      tr_cnt <= tr_cnt + 6'd1;
    end
  end

  // Drain timer: loaded on the last issue, counts down until that tag emerges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drain_cnt <= '0;
    end else if (last_issue) begin
      drain_cnt <= DRAIN_INIT;
    end else if (state == ST_DRAIN && drain_cnt != '0) begin
      drain_cnt <= drain_cnt - 1'b1;
    end
  end

  // Registered result pulses; found and done may coincide on the final tag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      found_valid <= 1'b0;
      found_nonce <= 32'd0;
      done        <= 1'b0;
    end else begin
      found_valid <= hit;
      if (hit) begin
        found_nonce <= tag_nonce;
      end
      done <= abort_hit || drain_last;
    end
  end

`ifdef SHA256_SCHED_STATS_EN
  // Saturating count of results that carried a valid tag in the current job
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hash_count <= 32'd0;
    end else if (accept) begin
      hash_count <= 32'd0;
    end else if (tag_valid && hash_count != 32'hFFFFFFFF) begin
      hash_count <= hash_count + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_sha256_loop_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_sha256_loop_sched
// Description : Scoreboard bench for sha256_loop_sched with a latency-matched
//               transform stub that returns a zero top word for chosen nonces.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sha256_loop_sched;

  localparam int LOOP = 4;
  localparam int LAT  = 66;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         work_valid;
  logic         work_ready;
  logic [255:0] work_midstate;
  logic [95:0]  work_data;
  logic [31:0]  nonce_start;
  logic [31:0]  nonce_end;
  logic         abort;
  logic         tr_feedback;
  logic [5:0]   tr_cnt;
  logic [255:0] tr_state;
  logic [511:0] tr_input;
  logic [255:0] tr_hash;
  logic         found_valid;
  logic [31:0]  found_nonce;
  logic         done;
`ifdef SHA256_SCHED_STATS_EN
  logic [31:0]  hash_count;
`endif

  always #5 clk = ~clk;

  sha256_loop_sched #(.LOOP(LOOP), .LAT(LAT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .work_valid   (work_valid),
    .work_ready   (work_ready),
    .work_midstate(work_midstate),
    .work_data    (work_data),
    .nonce_start  (nonce_start),
    .nonce_end    (nonce_end),
    .abort        (abort),
    .tr_feedback  (tr_feedback),
    .tr_cnt       (tr_cnt),
    .tr_state     (tr_state),
    .tr_input     (tr_input),
    .tr_hash      (tr_hash),
    .found_valid  (found_valid),
    .found_nonce  (found_nonce),
    .done         (done)
`ifdef SHA256_SCHED_STATS_EN
    ,
    .hash_count   (hash_count)
`endif
  );

  typedef struct packed {
    logic [31:0] nonce;
    logic [31:0] cyc;
  } ev_t;

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          acc_cyc = 0;
  logic [255:0] exp_mid;
  logic [95:0]  exp_data;
  bit          first_issue = 1'b0;
  bit          mon_en = 1'b0;
  logic [31:0] last_nonce;
  ev_t         q_issue[$];
  ev_t         q_found[$];
  int          q_done[$];

  localparam logic [255:0] MID1 = {8{32'h6A09E667}};
  localparam logic [255:0] MID2 = {8{32'hBB67AE85}};
  localparam logic [95:0]  DAT1 = {32'h11111111, 32'h22222222, 32'h33333333};
  localparam logic [95:0]  DAT2 = {32'hCAFEF00D, 32'h0BADBEEF, 32'h12345678};

  // Transform stub: winners produce a zero top word LAT cycles after issue
  logic [31:0] win [4];
  int          nwin = 0;
  logic [31:0] hpipe [LAT];

  function automatic bit is_win(input logic [31:0] n);
    for (int i = 0; i < 4; i++) begin
      if (i < nwin && win[i] == n) return 1'b1;
    end
    return 1'b0;
  endfunction

  initial begin
    for (int i = 0; i < LAT; i++) hpipe[i] = 32'hFFFFFFFF;
  end

  always @(posedge clk) begin
    hpipe[0] <= is_win(tr_input[127:96]) ? 32'd0 : {1'b1, tr_input[126:96]};
    for (int i = 1; i < LAT; i++) hpipe[i] <= hpipe[i-1];
  end

  assign tr_hash = {hpipe[LAT-1], {7{32'h5A5A5A5A}}};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input logic [511:0] act, input logic [511:0] exp, input string nm);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string nm, input logic [31:0] act);
    total++;
    bad++;
    $display("FAIL %s: got %0h expected nothing (cycle %0d)", nm, act, cyc);
  endtask

  // Monitor: checks per-cycle outputs and pops scoreboard entries on DUT events
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      if (!work_ready) begin
        chk(tr_cnt, ((cyc - acc_cyc) % LOOP), "tr_cnt");
        chk(tr_feedback, (((cyc - acc_cyc) % LOOP) != 0), "tr_feedback");
        chk(tr_state, exp_mid, "tr_state");
        if (tr_cnt == 6'd0 && (first_issue || tr_input[127:96] != last_nonce)) begin
          first_issue = 1'b0;
          last_nonce  = tr_input[127:96];
          if (q_issue.size() == 0) begin
            fail_now("unexpected_issue", tr_input[127:96]);
          end else begin
            ev_t e;
            e = q_issue.pop_front();
            chk(tr_input[127:96], e.nonce, "issue_nonce");
            chk(cyc, e.cyc, "issue_cycle");
            chk(tr_input[511:128], {32'h00000280, 320'd0, 32'h80000000}, "issue_padding");
            chk(tr_input[95:0], exp_data, "issue_data");
          end
        end
      end else begin
        chk(tr_cnt, 6'd0, "idle_tr_cnt");
      end
      if (found_valid) begin
        if (q_found.size() == 0) begin
          fail_now("unexpected_found", found_nonce);
        end else begin
          ev_t e;
          e = q_found.pop_front();
          chk(found_nonce, e.nonce, "found_nonce");
          chk(cyc, e.cyc, "found_cycle");
        end
      end
      if (done) begin
        if (q_done.size() == 0) begin
          fail_now("unexpected_done", cyc);
        end else begin
          chk(cyc, q_done.pop_front(), "done_cycle");
        end
      end
    end
  end

  task automatic run_job(input logic [31:0] s, input logic [31:0] e,
                         input logic [255:0] mid, input logic [95:0] data,
                         input int n_issue, input bit exp_found, input int done_off);
    @(negedge clk);
    work_midstate = mid;
    work_data     = data;
    nonce_start   = s;
    nonce_end     = e;
    work_valid    = 1'b1;
    @(posedge clk);
    #1;
    work_valid  = 1'b0;
    acc_cyc     = cyc;
    exp_mid     = mid;
    exp_data    = data;
    first_issue = 1'b1;
    for (int k = 0; k < n_issue; k++) begin
      ev_t ev;
      ev.nonce = s + 32'(k);
      ev.cyc   = 32'(acc_cyc + LOOP * k);
      q_issue.push_back(ev);
      if (exp_found && is_win(ev.nonce)) begin
        ev.cyc = 32'(acc_cyc + LOOP * k + LAT + 1);
        q_found.push_back(ev);
      end
    end
    if (done_off >= 0) q_done.push_back(acc_cyc + done_off);
  endtask

  task automatic wait_done(input string nm);
    int i;
    for (i = 0; i < 2000; i++) begin
      @(posedge clk);
      if (q_done.size() == 0 && work_ready) break;
    end
    if (i >= 2000) fail_now({nm, "_timeout"}, 32'(q_done.size()));
    repeat (3) @(posedge clk);
    chk(q_issue.size(), 0, {nm, "_issues_left"});
    chk(q_found.size(), 0, {nm, "_founds_left"});
  endtask

  initial begin
    rst_n = 1'b0;
    work_valid = 1'b0;
    work_midstate = '0;
    work_data = '0;
    nonce_start = '0;
    nonce_end = '0;
    abort = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk(tr_cnt, 6'd0, "rst_tr_cnt");
    chk(tr_feedback, 1'b0, "rst_tr_feedback");
    chk(tr_state, 256'd0, "rst_tr_state");
    chk(tr_input, 512'd0, "rst_tr_input");
    chk(found_valid, 1'b0, "rst_found_valid");
    chk(found_nonce, 32'd0, "rst_found_nonce");
    chk(done, 1'b0, "rst_done");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk(work_ready, 1'b1, "rst_work_ready");
    mon_en = 1'b1;

    // Range 0..3, no winners: done LAT+13 edges after the accept edge
    nwin = 0;
    run_job(32'd0, 32'd3, MID1, DAT1, 4, 1'b1, LAT + 13);
    wait_done("basic");

    // Single nonce 5 that wins: found and done together
    win[0] = 32'd5; nwin = 1;
    run_job(32'd5, 32'd5, MID2, DAT2, 1, 1'b1, LAT + 1);
    wait_done("single");

    // Wrapping range with two winners straddling the wrap
    win[0] = 32'hFFFFFFFF; win[1] = 32'd0; nwin = 2;
    run_job(32'hFFFFFFFE, 32'h00000001, MID1, DAT2, 4, 1'b1, LAT + 13);
    wait_done("wrap");

    // New work offered while busy must not disturb the running job
    nwin = 0;
    run_job(32'd10, 32'd12, MID1, DAT1, 3, 1'b1, LAT + 9);
    work_midstate = MID2;
    nonce_start   = 32'h500;
    nonce_end     = 32'h600;
    work_valid    = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    work_valid = 1'b0;
    wait_done("busy_offer");

    // Abort 10 cycles in with winners still in flight
    win[0] = 32'd2; win[1] = 32'd3; win[2] = 32'd50; nwin = 3;
    run_job(32'd0, 32'd100, MID2, DAT1, 3, 1'b0, 11);
    repeat (10) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk(work_ready, 1'b1, "abort_ready");
    chk(done, 1'b1, "abort_done");
    repeat (LAT + 20) @(posedge clk);
    chk(q_done.size(), 0, "abort_done_left");
    chk(q_issue.size(), 0, "abort_issues_left");

    // Reset during DRAIN: immediate clear, no done, then a fresh job
    nwin = 0;
    run_job(32'd0, 32'd0, MID2, DAT2, 1, 1'b0, -1);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk(tr_state, 256'd0, "async_tr_state");
    chk(tr_input, 512'd0, "async_tr_input");
    chk(tr_cnt, 6'd0, "async_tr_cnt");
    chk(tr_feedback, 1'b0, "async_tr_feedback");
    chk(found_valid, 1'b0, "async_found_valid");
    chk(done, 1'b0, "async_done");
    chk(q_issue.size(), 0, "prereset_issues_left");
    q_issue.delete();
    q_found.delete();
    q_done.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk(work_ready, 1'b1, "post_reset_ready");
    repeat (LAT + 5) @(posedge clk);
    win[0] = 32'd7; nwin = 1;
    run_job(32'd7, 32'd7, MID1, DAT2, 1, 1'b1, LAT + 1);
    wait_done("after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute guard so the run can never hang
  initial begin
    #2000000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
